// File: rtl/spi_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_assembler
// Description : UART-to-SPI command front end. Collects opcode-led UART frames
//               into {addr, data} commands, queues them in a small FIFO and
//               hands them one at a time to the SPI master using an enable
//               pulse plus the master's busy handshake. A second frame type
//               updates the SPI clock divider at run time.
//
//   Ports
//     clk_150MHz_i  in   system clock, rising edge
//     reset_n       in   asynchronous active-low reset (released synchronously)
//     rx_uart_data  in   received UART byte, valid while rx_ready=1
//     rx_ready      in   one-cycle byte strobe
//     busy          in   SPI master transfer in progress
//     clk_div       out  SPI clock divider
//     addr          out  address of the current / last issued command
//     tx_data       out  data of the current / last issued command
//     enable        out  one-cycle start pulse to the SPI master
//     fifo_level    out  number of queued commands
//     frame_err     out  pulse: bad opcode, inter-byte timeout, zero divider
//     overflow      out  pulse: complete command dropped because FIFO full
//     ack_timeout   out  pulse: busy never rose after enable
//
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_assembler #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] DIV_DEFAULT = 32'd1,
    parameter int          TIMEOUT_CYC = 150000,
    parameter int          ACK_CYC     = 16
) (
    input  logic                        clk_150MHz_i,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_uart_data,
    input  logic                        rx_ready,
    input  logic                        busy,
    output logic [31:0]                 clk_div,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        enable,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        overflow,
    output logic                        ack_timeout
);

    localparam int c_CMD_W      = ADDR_W + DATA_W;
    // The shift register must hold either a full command or a 32-bit divider.
    localparam int c_SR_W       = (c_CMD_W > 32) ? c_CMD_W : 32;
    localparam int c_XFER_BYTES = c_CMD_W / 8;
    localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int c_TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int c_ACK_W      = $clog2(ACK_CYC + 1);

    localparam logic [7:0] c_OP_XFER = 8'hA5;
    localparam logic [7:0] c_OP_DIV  = 8'h5A;

    localparam logic       c_RX_IDLE      = 1'b0;
    localparam logic       c_RX_COLLECT   = 1'b1;

    localparam logic [1:0] c_TX_IDLE      = 2'd0;
    localparam logic [1:0] c_TX_ISSUE     = 2'd1;
    localparam logic [1:0] c_TX_WAIT_ACK  = 2'd2;
    localparam logic [1:0] c_TX_WAIT_DONE = 2'd3;

    // ------------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_150MHz_i or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // RX side: frame assembly
    // ------------------------------------------------------------------------
    logic               r_rx_state;
    logic               r_is_div;
    logic [7:0]         r_bytes_left;
    logic [c_SR_W-1:0]  r_shift;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_push_pend;
    logic               r_div_pend;
    logic               r_frame_err;
    logic [31:0]        r_clk_div;

    logic w_rx_next;
    logic w_frame_start;
    logic w_last_byte;
    logic w_bad_op;
    logic w_rx_tmo;
    logic w_div_zero;
    logic w_div_load;

    always_comb begin
        w_rx_next     = r_rx_state;
        w_frame_start = 1'b0;
        w_last_byte   = 1'b0;
        w_bad_op      = 1'b0;
        w_rx_tmo      = 1'b0;
        case (r_rx_state)
            c_RX_IDLE: begin
                if (rx_ready) begin
                    if (rx_uart_data == c_OP_XFER || rx_uart_data == c_OP_DIV) begin
                        w_frame_start = 1'b1;
                        w_rx_next     = c_RX_COLLECT;
                    end else begin
                        w_bad_op = 1'b1;
                    end
                end
            end
            c_RX_COLLECT: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_ready) begin
                    if (r_bytes_left == 8'd1) begin
                        w_last_byte = 1'b1;
                        w_rx_next   = c_RX_IDLE;
                    end
                end else if (r_timer == c_TMR_W'(TIMEOUT_CYC)) begin
                    w_rx_tmo  = 1'b1;
                    w_rx_next = c_RX_IDLE;
                end
            end
            default: w_rx_next = c_RX_IDLE;
        endcase
    end

    // The completed divider value is still in the shift register during the
    // cycle after its last byte; RX is idle then so nothing shifts it away.
    assign w_div_zero = r_div_pend && (r_shift[31:0] == 32'd0);
    assign w_div_load = r_div_pend && (r_shift[31:0] != 32'd0);

    always_ff @(posedge clk_150MHz_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_state   <= c_RX_IDLE;
            r_is_div     <= 1'b0;
            r_bytes_left <= 8'd0;
            r_shift      <= '0;
            r_timer      <= '0;
            r_push_pend  <= 1'b0;
            r_div_pend   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_clk_div    <= DIV_DEFAULT;
        end else begin
            r_rx_state  <= w_rx_next;
            r_push_pend <= w_last_byte && !r_is_div;
            r_div_pend  <= w_last_byte && r_is_div;
            r_frame_err <= w_bad_op || w_rx_tmo || w_div_zero;
            if (w_div_load) r_clk_div <= r_shift[31:0];

            if (w_frame_start) begin
                r_is_div     <= (rx_uart_data == c_OP_DIV);
                r_bytes_left <= (rx_uart_data == c_OP_DIV) ? 8'd4 : 8'(c_XFER_BYTES);
                r_timer      <= '0;
            end else if (r_rx_state == c_RX_COLLECT) begin
                if (rx_ready) begin
                    r_shift      <= {r_shift[c_SR_W-9:0], rx_uart_data};
                    r_bytes_left <= r_bytes_left - 8'd1;
                    r_timer      <= '0;
                end else if (w_rx_tmo) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [c_CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;
    logic               r_overflow;
    logic [1:0]         r_tx_state;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Fullness is judged on the pre-pop count: a same-cycle pop does not make room.
    assign w_full = (r_count == c_LVL_W'(FIFO_DEPTH));
    assign w_push = r_push_pend && !w_full;
    assign w_pop  = (r_tx_state == c_TX_ISSUE);

    always_ff @(posedge clk_150MHz_i) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift[c_CMD_W-1:0];
    end

    always_ff @(posedge clk_150MHz_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push_pend && w_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // TX side: issue and busy handshake
    // ------------------------------------------------------------------------
    logic [1:0]         w_tx_next;
    logic               w_ack_tmo;
    logic [c_ACK_W-1:0] r_ack_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_ack_timeout;

    always_comb begin
        w_tx_next = r_tx_state;
        w_ack_tmo = 1'b0;
        case (r_tx_state)
            c_TX_IDLE:      if (r_count != '0 && !busy) w_tx_next = c_TX_ISSUE;
            c_TX_ISSUE:     w_tx_next = c_TX_WAIT_ACK;
            c_TX_WAIT_ACK: begin
                if (busy) begin
                    w_tx_next = c_TX_WAIT_DONE;
                end else if (r_ack_cnt == c_ACK_W'(ACK_CYC - 1)) begin
                    w_ack_tmo = 1'b1;
                    w_tx_next = c_TX_IDLE;
                end
            end
            c_TX_WAIT_DONE: if (!busy) w_tx_next = c_TX_IDLE;
            default:        w_tx_next = c_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_150MHz_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_state    <= c_TX_IDLE;
            r_ack_cnt     <= '0;
            r_addr        <= '0;
            r_tx_data     <= '0;
            r_ack_timeout <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_next;
            r_ack_timeout <= w_ack_tmo;
            if (r_tx_state == c_TX_WAIT_ACK) r_ack_cnt <= r_ack_cnt + 1'b1;
            else                             r_ack_cnt <= '0;
            // Load on entry to ISSUE so addr/tx_data are valid alongside enable.
            if (r_tx_state == c_TX_IDLE && w_tx_next == c_TX_ISSUE) begin
                {r_addr, r_tx_data} <= r_mem[r_rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign clk_div     = r_clk_div;
    assign addr        = r_addr;
    assign tx_data     = r_tx_data;
    assign enable      = (r_tx_state == c_TX_ISSUE);
    assign fifo_level  = r_count;
    assign frame_err   = r_frame_err;
    assign overflow    = r_overflow;
    assign ack_timeout = r_ack_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_assembler
// Description : Self-checking bench for spi_cmd_assembler. Frames are driven
//               byte by byte; a queue-based model of the command stream, the
//               divider value and the expected pulse counts is compared with
//               what the DUT issues to a simple SPI-master busy responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_assembler;
    localparam int TMO   = 300;
    localparam int ACK   = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_uart_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        busy = 1'b0;
    logic [31:0] clk_div;
    logic [31:0] addr;
    logic [15:0] tx_data;
    logic        enable;
    logic [2:0]  fifo_level;
    logic        frame_err;
    logic        overflow;
    logic        ack_timeout;

    spi_cmd_assembler #(
        .ADDR_W(32), .DATA_W(16), .FIFO_DEPTH(DEPTH), .DIV_DEFAULT(32'd1),
        .TIMEOUT_CYC(TMO), .ACK_CYC(ACK)
    ) dut (
        .clk_150MHz_i(clk), .reset_n(rst_n), .rx_uart_data(rx_uart_data),
        .rx_ready(rx_ready), .busy(busy), .clk_div(clk_div), .addr(addr),
        .tx_data(tx_data), .enable(enable), .fifo_level(fifo_level),
        .frame_err(frame_err), .overflow(overflow), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int en_count = 0, fe_count = 0, ov_count = 0, at_count = 0, at_cyc = 0;
    logic [47:0] en_log[$];
    int          en_cyc_q[$];
    bit auto_busy = 1'b0;
    bit busy_force = 1'b0;
    int hold = 0;
    int en_seen = 0;
    int last_rx_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT pulses, away from the active edge.
    always @(negedge clk) begin
        if (enable) begin
            en_log.push_back({addr, tx_data});
            en_cyc_q.push_back(cyc);
            en_count++;
        end
        if (frame_err) fe_count++;
        if (overflow) ov_count++;
        if (ack_timeout) begin
            at_count++;
            at_cyc = cyc;
        end
    end

    // SPI master stand-in: raises busy the cycle after enable for a few cycles.
    always @(posedge clk) begin
        #1;
        if (auto_busy) begin
            if (en_count != en_seen) begin
                en_seen = en_count;
                hold = $urandom_range(2, 4);
            end
            if (hold > 0) begin
                busy = 1'b1;
                hold--;
            end else begin
                busy = 1'b0;
            end
        end else begin
            en_seen = en_count;
            hold = 0;
            busy = busy_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers (all start/end at posedge+1) ----------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_ready = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        rx_uart_data = b;
        rx_ready     = 1'b1;
        last_rx_cyc  = cyc;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_xfer(input logic [31:0] a, input logic [15:0] d, input int gmin, input int gmax);
        logic [47:0] w;
        w = {a, d};
        send_byte(8'hA5, gmin);
        for (int i = 5; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(gmin, gmax));
    endtask

    task automatic send_div(input logic [31:0] v, input int gmin, input int gmax);
        send_byte(8'h5A, gmin);
        for (int i = 3; i >= 0; i--) send_byte(v[i*8 +: 8], $urandom_range(gmin, gmax));
    endtask

    task automatic wait_enables(input int target, input int budget);
        int k;
        k = 0;
        while (en_count < target && k < budget) begin @(posedge clk); #1; k++; end
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        n_chk++; if (clk_div !== 32'd1) begin n_err++; $display("FAIL reset_clk_div: got %h need %h", clk_div, 32'd1); end
        n_chk++; if (addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h need 0", addr); end
        n_chk++; if (tx_data !== 16'd0) begin n_err++; $display("FAIL reset_tx_data: got %h need 0", tx_data); end
        n_chk++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_fifo_level: got %0d need 0", fifo_level); end
        n_chk++; if ({enable, frame_err, overflow, ack_timeout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pulses: got %b need 0000", {enable, frame_err, overflow, ack_timeout});
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic_transfer;
        int e0;
        auto_busy = 1'b1;
        e0 = en_count;
        send_xfer(32'h0000_0012, 16'hABCD, 0, 0);
        wait_enables(e0 + 1, 40);
        tick(20);
        n_chk++; if (en_count !== e0 + 1) begin n_err++; $display("FAIL basic_enable_count: got %0d need %0d", en_count - e0, 1); end
        if (en_log.size() > e0) begin
            n_chk++; if (en_cyc_q[e0] - last_rx_cyc !== 3) begin n_err++; $display("FAIL basic_latency: got %0d need 3", en_cyc_q[e0] - last_rx_cyc); end
            n_chk++; if (en_log[e0] !== {32'h0000_0012, 16'hABCD}) begin n_err++; $display("FAIL basic_cmd: got %h need %h", en_log[e0], {32'h0000_0012, 16'hABCD}); end
        end
        n_chk++; if ({addr, tx_data} !== {32'h0000_0012, 16'hABCD}) begin n_err++; $display("FAIL basic_hold: got %h need %h", {addr, tx_data}, {32'h0000_0012, 16'hABCD}); end
        n_chk++; if (clk_div !== 32'd1) begin n_err++; $display("FAIL basic_clk_div: got %h need 1", clk_div); end
    endtask

    task automatic test_divider;
        int f0;
        f0 = fe_count;
        send_div(32'd8, 1, 1);
        tick(4);
        n_chk++; if (clk_div !== 32'd8) begin n_err++; $display("FAIL div_load: got %h need 8", clk_div); end
        send_div(32'd0, 1, 1);
        tick(4);
        n_chk++; if (fe_count - f0 !== 1) begin n_err++; $display("FAIL div_zero_err: got %0d pulses need 1", fe_count - f0); end
        n_chk++; if (clk_div !== 32'd8) begin n_err++; $display("FAIL div_zero_keep: got %h need 8", clk_div); end
    endtask

    task automatic test_overflow;
        int e0, o0;
        logic [47:0] sent[$];
        logic [31:0] a;
        logic [15:0] d;
        auto_busy = 1'b0; busy_force = 1'b1;
        tick(2);
        e0 = en_count; o0 = ov_count;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; d = 16'($urandom);
            sent.push_back({a, d});
            send_xfer(a, d, 0, 1);
            tick(1);
        end
        tick(5);
        n_chk++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL ovf_level: got %0d need %0d", fifo_level, DEPTH); end
        n_chk++; if (ov_count - o0 !== 1) begin n_err++; $display("FAIL ovf_pulses: got %0d need 1", ov_count - o0); end
        n_chk++; if (en_count - e0 !== 0) begin n_err++; $display("FAIL ovf_no_issue_while_busy: got %0d enables need 0", en_count - e0); end
        auto_busy = 1'b1;
        wait_enables(e0 + DEPTH, 200);
        tick(30);
        n_chk++; if (en_count - e0 !== DEPTH) begin n_err++; $display("FAIL ovf_drain_count: got %0d need %0d", en_count - e0, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            if (en_log.size() > e0 + i) begin
                n_chk++;
                if (en_log[e0 + i] !== sent[i]) begin n_err++; $display("FAIL ovf_order[%0d]: got %h need %h", i, en_log[e0 + i], sent[i]); end
            end
        end
        n_chk++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL ovf_empty: got %0d need 0", fifo_level); end
    endtask

    task automatic test_timeout;
        int f0, e0;
        logic [31:0] a;
        logic [15:0] d;
        auto_busy = 1'b1;
        f0 = fe_count;
        send_byte(8'hA5, 1); send_byte(8'h00, 0); send_byte(8'h00, 0);
        tick(TMO + 10);
        n_chk++; if (fe_count - f0 !== 1) begin n_err++; $display("FAIL tmo_pulse: got %0d need 1", fe_count - f0); end
        e0 = en_count;
        a = $urandom; d = 16'($urandom);
        send_xfer(a, d, 1, 2);
        wait_enables(e0 + 1, 40);
        n_chk++; if (en_count !== e0 + 1) begin n_err++; $display("FAIL tmo_recover_count: got %0d need 1", en_count - e0); end
        else begin
            n_chk++; if (en_log[e0] !== {a, d}) begin n_err++; $display("FAIL tmo_recover_cmd: got %h need %h", en_log[e0], {a, d}); end
        end
        // Exactly TMO idle cycles between bytes is still allowed.
        f0 = fe_count; e0 = en_count;
        a = $urandom; d = 16'($urandom);
        send_byte(8'hA5, 2);
        send_byte(a[31:24], TMO);
        send_byte(a[23:16], 0); send_byte(a[15:8], 0); send_byte(a[7:0], 0);
        send_byte(d[15:8], 0); send_byte(d[7:0], 0);
        wait_enables(e0 + 1, 40);
        n_chk++; if (fe_count - f0 !== 0) begin n_err++; $display("FAIL tmo_edge_err: got %0d pulses need 0", fe_count - f0); end
        n_chk++; if (en_count !== e0 + 1) begin n_err++; $display("FAIL tmo_edge_count: got %0d need 1", en_count - e0); end
        else begin
            n_chk++; if (en_log[e0] !== {a, d}) begin n_err++; $display("FAIL tmo_edge_cmd: got %h need %h", en_log[e0], {a, d}); end
        end
        // One more idle cycle expires the frame; the late byte is then an opcode.
        f0 = fe_count;
        send_byte(8'hA5, 2);
        send_byte(8'h77, TMO + 1);
        tick(4);
        n_chk++; if (fe_count - f0 !== 2) begin n_err++; $display("FAIL tmo_late_err: got %0d pulses need 2", fe_count - f0); end
    endtask

    task automatic test_ack_timeout;
        int e0, a0, k;
        logic [31:0] a1, a2;
        logic [15:0] d1, d2;
        auto_busy = 1'b0; busy_force = 1'b0;
        tick(2);
        e0 = en_count; a0 = at_count;
        a1 = $urandom; d1 = 16'($urandom); a2 = $urandom; d2 = 16'($urandom);
        send_xfer(a1, d1, 0, 0);
        send_xfer(a2, d2, 0, 0);
        k = 0;
        while (at_count < a0 + 1 && k < 150) begin tick(1); k++; end
        n_chk++; if (at_count - a0 !== 1) begin n_err++; $display("FAIL ack_pulse: got %0d need 1", at_count - a0); end
        else if (en_cyc_q.size() > e0) begin
            n_chk++;
            if (at_cyc - en_cyc_q[e0] < ACK || at_cyc - en_cyc_q[e0] > ACK + 2) begin
                n_err++; $display("FAIL ack_delay: got %0d cycles need %0d..%0d", at_cyc - en_cyc_q[e0], ACK, ACK + 2);
            end
        end
        wait_enables(e0 + 2, 60);
        tick(40);
        n_chk++; if (en_count - e0 !== 2) begin n_err++; $display("FAIL ack_no_retry: got %0d enables need 2", en_count - e0); end
        else begin
            n_chk++; if (en_log[e0] !== {a1, d1}) begin n_err++; $display("FAIL ack_cmd1: got %h need %h", en_log[e0], {a1, d1}); end
            n_chk++; if (en_log[e0 + 1] !== {a2, d2}) begin n_err++; $display("FAIL ack_cmd2: got %h need %h", en_log[e0 + 1], {a2, d2}); end
        end
        n_chk++; if (at_count - a0 !== 2) begin n_err++; $display("FAIL ack_second: got %0d pulses need 2", at_count - a0); end
    endtask

    task automatic test_random;
        int e0, f0, o0, fe_exp;
        logic [47:0] exp_q[$];
        logic [31:0] exp_div, a, v;
        logic [15:0] d;
        auto_busy = 1'b1;
        tick(2);
        e0 = en_count; f0 = fe_count; o0 = ov_count;
        fe_exp = 0; exp_div = clk_div;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                a = $urandom; d = 16'($urandom);
                exp_q.push_back({a, d});
                send_xfer(a, d, 1, 3);
            end else begin
                v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                if (v == 32'd0) fe_exp++;
                else            exp_div = v;
                send_div(v, 1, 3);
            end
        end
        wait_enables(e0 + exp_q.size(), 300);
        tick(20);
        n_chk++; if (en_count - e0 !== exp_q.size()) begin n_err++; $display("FAIL rnd_count: got %0d need %0d", en_count - e0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (en_log.size() > e0 + i) begin
                n_chk++;
                if (en_log[e0 + i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_cmd[%0d]: got %h need %h", i, en_log[e0 + i], exp_q[i]); end
            end
        end
        n_chk++; if (fe_count - f0 !== fe_exp) begin n_err++; $display("FAIL rnd_frame_err: got %0d need %0d", fe_count - f0, fe_exp); end
        n_chk++; if (ov_count - o0 !== 0) begin n_err++; $display("FAIL rnd_overflow: got %0d need 0", ov_count - o0); end
        n_chk++; if (clk_div !== exp_div) begin n_err++; $display("FAIL rnd_clk_div: got %h need %h", clk_div, exp_div); end
    endtask

    task automatic test_bad_op_reset;
        int f0, e0, k;
        auto_busy = 1'b0; busy_force = 1'b0;
        f0 = fe_count;
        send_byte(8'h33, 1);
        tick(4);
        n_chk++; if (fe_count - f0 !== 1) begin n_err++; $display("FAIL badop_pulse: got %0d need 1", fe_count - f0); end
        e0 = en_count;
        send_xfer($urandom, 16'($urandom), 0, 1);
        wait_enables(e0 + 1, 40);
        busy_force = 1'b1;
        tick(3);
        send_xfer($urandom, 16'($urandom), 0, 1);
        tick(4);
        n_chk++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL rst_pre_level: got %0d need 1", fifo_level); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (enable !== 1'b0) begin n_err++; $display("FAIL rst_enable: got %b need 0", enable); end
        n_chk++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d need 0", fifo_level); end
        n_chk++; if (clk_div !== 32'd1) begin n_err++; $display("FAIL rst_clk_div: got %h need 1", clk_div); end
        tick(3);
        busy_force = 1'b0;
        rst_n = 1'b1;
        tick(4);
        e0 = en_count;
        tick(30);
        n_chk++; if (en_count - e0 !== 0) begin n_err++; $display("FAIL rst_fifo_flushed: got %0d enables need 0", en_count - e0); end
        // Reset landing on the enable cycle itself.
        send_xfer($urandom, 16'($urandom), 0, 0);
        k = 0;
        while (enable !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        n_chk++; if (enable !== 1'b1) begin n_err++; $display("FAIL rst_issue_seen: got %b need 1", enable); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (enable !== 1'b0) begin n_err++; $display("FAIL rst_issue_drop: got %b need 0", enable); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_basic_transfer();
        test_divider();
        test_overflow();
        test_timeout();
        test_ack_timeout();
        test_random();
        test_bad_op_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
